out_down_sched: RTL



---
 rtl/out_down_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/out_down_sched.sv
// -----------------------------------------------------------------------------
// out_down_sched
//
// Shared output-downscale scheduler. Up to NREQ accumulator lanes are
// arbitrated round-robin into one shift-and-narrow stage. The granted
// accumulator is arithmetic-shifted right by `div`, narrowed to featureWidth
// bits, and returned together with its lane id over a valid/ready handshake.
//
// Each result takes one capture cycle (SCALE) and is then presented (OUT).
// Accept in cycle t gives out_valid in cycle t+2. With continuous requests
// and out_ready high, a new lane is accepted in the same cycle that the
// previous result hands off, so one result comes out every 2 cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low; clears all state
//   enable     low: no new grants; a held result still drains
//   req_valid  [NREQ]       lane i has a result pending
//   req_data   [NREQ*ACCW]  signed accumulator of lane i at [i*ACCW +: ACCW]
//   req_ready  [NREQ]       combinational one-hot grant
//   out_valid               out_data/out_id are valid
//   out_ready               consumer accepts when out_valid & out_ready
//   out_data   [featureWidth] scaled result, signed
//   out_id     [IDW]        lane that produced out_data
//   busy                    high whenever the unit is not idle
//
// Configuration macro: OUT_DOWN_SAT_EN
//   defined   -> shifted value saturates to the signed featureWidth range
//   undefined -> low featureWidth bits are kept (wraps on overflow)
// -----------------------------------------------------------------------------
module out_down_sched #(
    parameter int weightWidth  = 16,
    parameter int featureWidth = 16,
    parameter int div          = 7,
    parameter int NREQ         = 4,
    parameter int IDW          = 2,
    localparam int ACCW        = featureWidth + weightWidth + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ACCW-1:0]     req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [featureWidth-1:0]  out_data,
    output logic [IDW-1:0]           out_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCALE = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [IDW-1:0]           r_ptr;
    logic signed [ACCW-1:0]   r_acc;
    logic [IDW-1:0]           r_id;
    logic [featureWidth-1:0]  r_out_data;
    logic [IDW-1:0]           r_out_id;

    logic                     w_accept;
    logic [IDW-1:0]           w_win;
    logic [ACCW-1:0]          w_win_data;
    logic [NREQ-1:0]          w_onehot;
    int                       w_best;
    logic signed [ACCW-1:0]   w_shifted;
    logic [featureWidth-1:0]  w_narrow;

    // A new lane may enter only when nothing is held, or when the held
    // result leaves in this very cycle.
    assign w_accept = enable && (|req_valid) &&
                      ((r_state == S_IDLE) || ((r_state == S_OUT) && out_ready));

    // Round-robin: each valid lane's distance from ptr+1 (mod NREQ) is its
    // priority; the smallest distance wins. Data is picked in the same pass
    // so only constant lane indices are ever used.
    always_comb begin : rr_search
        // NOTE: every variable gets a default before any condition so that
        // no path leaves it unassigned, which would otherwise infer a latch.
        w_best     = NREQ;
        w_win      = '0;
        w_win_data = '0;
        w_onehot   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (((i + NREQ - 1 - int'(r_ptr)) % NREQ) < w_best)) begin
                w_best      = (i + NREQ - 1 - int'(r_ptr)) % NREQ;
                w_win       = IDW'(i);
                w_win_data  = req_data[i*ACCW +: ACCW];
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign req_ready = w_accept ? w_onehot : '0;

    assign w_shifted = r_acc >>> div;

`ifdef OUT_DOWN_SAT_EN
    logic [ACCW-featureWidth:0] w_hi;
    logic                       w_in_range;

    // The value fits when every bit from the narrow sign bit upward agrees.
    assign w_hi       = w_shifted[ACCW-1:featureWidth-1];
    assign w_in_range = (&w_hi) || !(|w_hi);
    assign w_narrow   = w_in_range      ? w_shifted[featureWidth-1:0] :
                        w_shifted[ACCW-1] ? {1'b1, {(featureWidth-1){1'b0}}} :
                                            {1'b0, {(featureWidth-1){1'b1}}};
`else
    assign w_narrow = featureWidth'(w_shifted);
`endif

    always_comb begin : next_state
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SCALE;
            S_SCALE: w_next_state = S_OUT;
            S_OUT:   if (out_ready) w_next_state = w_accept ? S_SCALE : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : datapath
        if (!reset) begin
            r_ptr      <= IDW'(NREQ - 1);
            r_acc      <= '0;
            r_id       <= '0;
            r_out_data <= '0;
            r_out_id   <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_win_data;
                r_id  <= w_win;
                r_ptr <= w_win;
            end
            if (r_state == S_SCALE) begin
                r_out_data <= w_narrow;
                r_out_id   <= r_id;
            end
        end
    end

    // The presented result is exactly the OUT state, so valid cannot
    // disagree with the FSM and drops on the handshake edge.
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
